adc_reader: RTL and testbench
=============================

ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 The block SHALL have parameter DIV, default 25, giving the SCK half-period in clk cycles; legal range is DIV >= 1.
REQ-002 The block SHALL have parameter FRAME, default 16, giving the SCK cycles per conversion frame; legal range is FRAME >= 12.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: a conversion request, sampled only in IDLE.
REQ-006 The block SHALL have port spi_miso, input, 1 bit: serial data from the ADC, MSB first.
REQ-007 The block SHALL have port spi_sck, output, 1 bit: the serial clock to the ADC, idle low.
REQ-008 The block SHALL have port adc_cs, output, 1 bit: the ADC chip select, active-low.
REQ-009 The block SHALL have port sample, output, 12 bits: the last completed conversion result.
REQ-010 The block SHALL have port valid, output, 1 bit: a one-clk strobe marking an updated sample.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL implement states IDLE, SETUP, SHIFT, DONE and QUIET, with every output registered.
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap, be cleared on the IDLE->SETUP transition and on entry to QUIET, and produce a tick during any cycle where it equals DIV-1.
REQ-014 In IDLE: adc_cs=1, spi_sck=0, busy=0; a clk edge with start=1 SHALL enter SETUP.
REQ-015 On entering SETUP, adc_cs SHALL go 0 and the bit counter and the FRAME-bit shift register SHALL clear.
REQ-016 SETUP SHALL last exactly DIV cycles, then enter SHIFT on the tick edge with spi_sck still 0.
REQ-017 In SHIFT, on a tick edge with spi_sck=0, spi_sck SHALL go 1 and spi_miso SHALL shift into the LSB of the shift register (rising-edge capture).
REQ-018 In SHIFT, on a tick edge with spi_sck=1, spi_sck SHALL go 0 and the bit counter SHALL increment.
REQ-019 When the bit counter is FRAME-1 at that falling edge, the block SHALL enter DONE instead of incrementing.
REQ-020 SHIFT SHALL therefore span exactly 2*FRAME ticks (2*FRAME*DIV cycles).
REQ-021 On entering DONE: adc_cs=1, sample <= shift register bits [11:0] (the last 12 bits captured), and valid=1.
REQ-022 DONE SHALL last exactly one cycle, then enter QUIET, where valid=0 and adc_cs=1.
REQ-023 QUIET SHALL last DIV cycles (minimum CS-high time), then return to IDLE.
REQ-024 Latency SHALL be: with start sampled at edge e0, adc_cs low after e0, valid high for the single cycle after edge e0+(2*FRAME+1)*DIV, and busy low after edge e0+(2*FRAME+2)*DIV+1.
REQ-025 start SHALL be ignored in SETUP, SHIFT, DONE and QUIET, and no request SHALL be queued.
REQ-026 start held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle.
REQ-027 sample SHALL hold its value between frames and change only on DONE entry.
REQ-028 spi_miso SHALL be sampled directly, with no synchroniser (the ADC is timed from spi_sck).
REQ-029 The bit counter SHALL be wide enough for FRAME-1, and the prescaler wide enough for DIV-1.
REQ-030 With DIV=1, a tick SHALL occur every cycle, so spi_sck = clk/2.

Reset
REQ-031 When rst=0, the block SHALL immediately, without waiting for clk, force state=IDLE, adc_cs=1, spi_sck=0, valid=0, busy=0, sample=0, and clear the prescaler, bit counter and shift register.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no valid pulse, and sample SHALL read 0.
REQ-033 After rst releases, the block SHALL stay in IDLE until start is seen at a clk edge.

Verification (DIV=2, FRAME=16 unless stated)
REQ-034 Single frame with the ADC model returning 0000_1010_1100_0011: pulse start at e0 -> adc_cs low after e0; 16 spi_sck pulses each 2 clk high and 2 clk low; valid high one cycle after e66; sample=12'hAC3; busy low after e69.
REQ-035 All-ones spi_miso -> sample=12'hFFF; all-zeros -> sample=12'h000; the leading 4 bits never appear in sample.
REQ-036 start held high for 300 cycles -> successive frames, adc_cs high for exactly 2+1+1 cycles between frames, a valid pulse per frame, and no extra spi_sck edges.
REQ-037 start pulsed during SHIFT -> ignored, exactly one valid pulse, and frame timing unchanged.
REQ-038 rst driven low between clk edges at the 7th spi_sck rise -> adc_cs=1, spi_sck=0, sample=0 immediately; no valid; the next start produces a clean full frame.
REQ-039 DIV=1 -> spi_sck toggles every cycle in SHIFT, and valid is high after edge e33.

Source files
------------

// File: rtl/adc_reader.sv
// -----------------------------------------------------------------------------
// adc_reader
//
// SPI master for a 12-bit serial ADC. A start request opens a conversion
// frame: chip select drops, FRAME serial clock pulses are generated with a
// half-period of DIV clk cycles, and spi_miso is captured on every rising
// spi_sck edge. The last 12 bits captured become the sample, announced by a
// one-cycle valid strobe. A quiet period of DIV cycles keeps chip select
// high before the next frame can start.
//
// Ports
//   clk       in   system clock, all logic on its rising edge
//   rst       in   asynchronous active-low reset
//   start     in   conversion request, only looked at in IDLE
//   spi_miso  in   serial data from the ADC, MSB first
//   spi_sck   out  serial clock to the ADC, idle low
//   adc_cs    out  ADC chip select, active low
//   sample    out  last completed 12-bit conversion result
//   valid     out  one-cycle strobe when sample has been updated
//   busy      out  high whenever the block is not in IDLE
// -----------------------------------------------------------------------------
module adc_reader #(
    parameter int DIV   = 25,
    parameter int FRAME = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        adc_cs,
    output logic [11:0] sample,
    output logic        valid,
    output logic        busy
);

    // Prescaler needs at least one bit even when DIV=1 (it then stays at 0
    // and ticks every cycle).
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(FRAME);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t           r_state, w_state_next;
    logic [PW-1:0]    r_presc, w_presc_next;
    logic [CW-1:0]    r_bit_cnt, w_bit_cnt_next;
    logic [FRAME-1:0] r_shift, w_shift_next;
    logic             r_sck, w_sck_next;
    logic             r_cs, w_cs_next;
    logic             r_valid, w_valid_next;
    logic             r_busy, w_busy_next;
    logic [11:0]      r_sample, w_sample_next;

    logic             w_tick;
    // The oldest shift-register bit is shifted out and never read; it only
    // exists so the register is a full frame wide.
    logic             w_unused_msb;

    assign w_tick       = (r_presc == PW'(DIV - 1));
    assign w_unused_msb = r_shift[FRAME-1];

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_sample  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_sck     <= w_sck_next;
            r_cs      <= w_cs_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
            r_sample  <= w_sample_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = w_tick ? '0 : r_presc + 1'b1;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_sck_next     = r_sck;
        w_cs_next      = r_cs;
        w_valid_next   = 1'b0;
        w_sample_next  = r_sample;

        case (r_state)
            S_IDLE: begin
                w_cs_next  = 1'b1;
                w_sck_next = 1'b0;
                if (start) begin
                    w_state_next   = S_SETUP;
                    // Restart the prescaler so SETUP lasts exactly DIV cycles.
                    w_presc_next   = '0;
                    w_cs_next      = 1'b0;
                    w_bit_cnt_next = '0;
                    w_shift_next   = '0;
                end
            end

            S_SETUP: begin
                if (w_tick) begin
                    w_state_next = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (w_tick) begin
                    if (!r_sck) begin
                        // Rising edge: capture the bit the ADC presented on
                        // the previous falling edge (or on CS fall).
                        w_sck_next   = 1'b1;
                        w_shift_next = {r_shift[FRAME-2:0], spi_miso};
                    end else begin
                        w_sck_next = 1'b0;
                        if (r_bit_cnt == CW'(FRAME - 1)) begin
                            w_state_next  = S_DONE;
                            w_cs_next     = 1'b1;
                            w_sample_next = r_shift[11:0];
                            w_valid_next  = 1'b1;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_QUIET;
                // QUIET measures the CS-high time from a fresh count.
                w_presc_next = '0;
            end

            S_QUIET: begin
                if (w_tick) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cs_next    = 1'b1;
                w_sck_next   = 1'b0;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    assign spi_sck = r_sck;
    assign adc_cs  = r_cs;
    assign sample  = r_sample;
    assign valid   = r_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_adc_reader.sv
`timescale 1ns/1ps
module tb_adc_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        spi_miso;
    logic        spi_sck;
    logic        adc_cs;
    logic [11:0] sample;
    logic        valid;
    logic        busy;

    // Second instance with DIV=1 for the fastest serial clock.
    logic        start1;
    logic        miso1;
    logic        sck1;
    logic        cs1;
    logic [11:0] sample1;
    logic        valid1;
    logic        busy1;

    always #5 clk = ~clk;

    adc_reader #(.DIV(2), .FRAME(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .spi_miso (spi_miso),
        .spi_sck  (spi_sck),
        .adc_cs   (adc_cs),
        .sample   (sample),
        .valid    (valid),
        .busy     (busy)
    );

    adc_reader #(.DIV(1), .FRAME(16)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .spi_miso (miso1),
        .spi_sck  (sck1),
        .adc_cs   (cs1),
        .sample   (sample1),
        .valid    (valid1),
        .busy     (busy1)
    );

    // ADC model: MSB presented when CS falls, next bit on each SCK fall.
    logic [15:0] adc_word = 16'h0000;
    int          adc_idx  = 16;
    always @(negedge adc_cs) adc_idx = 0;
    always @(negedge spi_sck) if (!adc_cs) adc_idx = adc_idx + 1;
    assign spi_miso = (adc_idx < 16) ? adc_word[15 - adc_idx] : 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Observations from one frame, indexed by n = clk edges since e0.
    int obs_cs_low0, obs_valid_cnt, obs_valid_at, obs_idle_at, obs_rises, obs_high;

    task automatic run_frame(input logic [15:0] word, input int poke_at, input int ncyc);
        logic prev_sck;
        adc_word      = word;
        obs_cs_low0   = 0;
        obs_valid_cnt = 0;
        obs_valid_at  = -1;
        obs_idle_at   = -1;
        obs_rises     = 0;
        obs_high      = 0;
        prev_sck      = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            start = (n == poke_at);
            if (n == 0) obs_cs_low0 = int'(!adc_cs);
            if (valid) begin
                obs_valid_cnt++;
                if (obs_valid_at < 0) obs_valid_at = n;
            end
            if (!busy && obs_idle_at < 0) obs_idle_at = n;
            if (spi_sck && !prev_sck) obs_rises++;
            if (spi_sck) obs_high++;
            prev_sck = spi_sck;
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rises, high, vcnt, runs, run_len, first_valid;
        logic prev, seen_low, got7;

        rst    = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        miso1  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs",     32'(adc_cs),  32'd1);
        check("rst_sck",    32'(spi_sck), 32'd0);
        check("rst_valid",  32'(valid),   32'd0);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_sample", 32'(sample),  32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy), 32'd0);

        // Basic frame
        run_frame(16'h0AC3, -1, 100);
        check("f1_cs_low_e0",  32'(obs_cs_low0),   32'd1);
        check("f1_valid_at",   32'(obs_valid_at),  32'd66);
        check("f1_valid_cnt",  32'(obs_valid_cnt), 32'd1);
        check("f1_idle_at",    32'(obs_idle_at),   32'd69);
        check("f1_sck_rises",  32'(obs_rises),     32'd16);
        check("f1_sck_high",   32'(obs_high),      32'd32);
        check("f1_sample",     32'(sample),        32'hAC3);

        // Data patterns
        run_frame(16'hFFFF, -1, 100);
        check("ones_sample",   32'(sample),        32'hFFF);
        run_frame(16'h0000, -1, 100);
        check("zeros_sample",  32'(sample),        32'h000);
        run_frame(16'hF000, -1, 100);
        check("lead4_sample",  32'(sample),        32'h000);
        run_frame(16'h5A96, -1, 100);
        check("mix_sample",    32'(sample),        32'hA96);

        // start pulsed during SHIFT is ignored
        run_frame(16'h0123, 20, 150);
        check("poke_valid_cnt", 32'(obs_valid_cnt), 32'd1);
        check("poke_valid_at",  32'(obs_valid_at),  32'd66);
        check("poke_idle_at",   32'(obs_idle_at),   32'd69);
        check("poke_rises",     32'(obs_rises),     32'd16);
        check("poke_sample",    32'(sample),        32'h123);

        // start held high: back-to-back frames
        adc_word = 16'h0AC3;
        rises = 0; vcnt = 0; runs = 0; run_len = 0; first_valid = -1;
        prev = 1'b0; seen_low = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (valid) begin
                vcnt++;
                if (first_valid < 0) first_valid = n;
            end
            if (spi_sck && !prev && n < 280) rises++;
            prev = spi_sck;
            if (adc_cs) run_len++;
            else begin
                if (seen_low && run_len > 0) begin
                    runs++;
                    check("b2b_cs_high_len", 32'(run_len), 32'd4);
                end
                seen_low = 1'b1;
                run_len  = 0;
            end
        end
        start = 1'b0;
        check("b2b_valid_cnt",  32'(vcnt),        32'd4);
        check("b2b_first_valid", 32'(first_valid), 32'd66);
        check("b2b_cs_runs",    32'(runs),        32'd4);
        check("b2b_rises",      32'(rises),       32'd64);
        check("b2b_sample",     32'(sample),      32'hAC3);
        begin
            int k;
            k = 0;
            while (busy && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("b2b_drain_busy", 32'(busy), 32'd0);
        end
        repeat (3) @(negedge clk);

        // Reset mid-frame at the 7th SCK rise
        adc_word = 16'h0F0F;
        rises = 0; prev = 1'b0; got7 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 100 && !got7; n++) begin
            if (spi_sck && !prev) rises++;
            prev = spi_sck;
            if (rises == 7) got7 = 1'b1;
            else @(negedge clk);
        end
        check("rst7_reached", 32'(got7), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("midrst_cs",     32'(adc_cs),  32'd1);
        check("midrst_sck",    32'(spi_sck), 32'd0);
        check("midrst_sample", 32'(sample),  32'd0);
        check("midrst_busy",   32'(busy),    32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (valid || busy) vcnt++;
        end
        check("postrst_quiet",  32'(vcnt),   32'd0);
        check("postrst_sample", 32'(sample), 32'd0);
        run_frame(16'h0AC3, -1, 100);
        check("postrst_valid_at", 32'(obs_valid_at), 32'd66);
        check("postrst_rises",    32'(obs_rises),    32'd16);
        check("postrst_sample",   32'(sample),       32'hAC3);

        // DIV=1 instance
        rises = 0; high = 0; first_valid = -1; prev = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (valid1 && first_valid < 0) first_valid = n;
            if (sck1 && !prev) rises++;
            if (sck1) high++;
            prev = sck1;
        end
        check("div1_valid_at", 32'(first_valid), 32'd33);
        check("div1_rises",    32'(rises),       32'd16);
        check("div1_high",     32'(high),        32'd16);
        check("div1_sample",   32'(sample1),     32'hFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
